// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone arbiter.
//   Port 0 is instruction fetch and port 1 is the mem stage. A grant is held for the
//   owner's whole bus cycle (cyc high). Strobes raised while a port is not granted are
//   latched in a pend flag and forwarded once the port owns the bus. A starvation
//   counter forces port 0 to win arbitration after it has waited STARVE_MAX cycles.
// Parameters:
//   AW, DW      address / data width (byte selects are DW/8 wide)
//   RR          0 = fixed priority (port 1 wins ties), 1 = round-robin (last-granted loses ties)
//   STARVE_MAX  wait cycles of port 0 before it is forced to win
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   mN_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   master N request (N = 0,1)
//   mN_ack_o, mN_dat_o, mN_gnt_o  ack, read data and grant back to master N
//   s_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o    request forwarded to the slave
//   s_dat_i, s_ack_i              slave response
//   state_o                       arbiter state (0 idle, 1 port 0 owns, 2 port 1 owns)
// Handshake: a slave transfer is presented while s_cyc_o & s_stb_o; the slave answers
//   with a one-cycle s_ack_i, which is routed to the current owner only if that owner
//   still holds cyc. Acks arriving in idle or after an abort are dropped.
module wb_arbiter2 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RR         = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_gnt_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_gnt_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      state_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t        state;
  logic          pend0, pend1;
  logic          last_gnt;      // 1 when port 1 was granted most recently
  logic [CW-1:0] starve_cnt;

  logic starved, win1, arb, win0_now, lost0_now, fwd0, fwd1;

  // Winner of the arbitration that happens in S_IDLE. A lone requester always wins;
  // on a tie the starvation override beats the priority rule.
  always_comb begin
    starved = (starve_cnt == CW'(STARVE_MAX));
    if (!m0_cyc_i)      win1 = 1'b1;
    else if (!m1_cyc_i) win1 = 1'b0;
    else if (starved)   win1 = 1'b0;
    else if (RR == 0)   win1 = 1'b1;
    else                win1 = ~last_gnt;
  end

  assign arb       = (state == S_IDLE) && (m0_cyc_i || m1_cyc_i);
  assign win0_now  = arb && !win1;
  assign lost0_now = arb && m0_cyc_i && win1;

  assign m0_gnt_o = (state == S_GNT0);
  assign m1_gnt_o = (state == S_GNT1);
  assign state_o  = state;

  // A strobe counts as forwarded in any cycle its owner presents it to the slave.
  assign fwd0 = m0_gnt_o && (m0_stb_i || pend0);
  assign fwd1 = m1_gnt_o && (m1_stb_i || pend1);

  assign m0_ack_o = s_ack_i & m0_gnt_o & m0_cyc_i;
  assign m1_ack_o = s_ack_i & m1_gnt_o & m1_cyc_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (m0_gnt_o) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i | pend0;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (m1_gnt_o) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i | pend1;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_gnt   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      // Owner keeps the bus until it drops cyc; every hand-over passes through S_IDLE.
      case (state)
        S_IDLE: begin
          if (arb) begin
            state    <= win1 ? S_GNT1 : S_GNT0;
            last_gnt <= win1;
          end
        end
        S_GNT0:  if (!m0_cyc_i) state <= S_IDLE;
        S_GNT1:  if (!m1_cyc_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (!m0_cyc_i || fwd0)            pend0 <= 1'b0;
      else if (m0_stb_i && !m0_gnt_o)   pend0 <= 1'b1;

      if (!m1_cyc_i || fwd1)            pend1 <= 1'b0;
      else if (m1_stb_i && !m1_gnt_o)   pend1 <= 1'b1;

      // Counts cycles port 0 waits behind port 1, saturating at STARVE_MAX.
      if (!m0_cyc_i || m0_gnt_o || win0_now)
        starve_cnt <= '0;
      else if ((m1_gnt_o || lost0_now) && !starved)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule
